// File: rtl/video_dither_pkg.sv
// Shared constants and helpers for the VGA output dither stage:
// the 2x2 Bayer matrix and the per-pixel threshold scaling.
package video_dither_pkg;

  // Indexed as BAYER2[yi][xi].
  localparam logic [1:0] BAYER2 [2][2] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

  function automatic bit bpp_legal(input int bpp);
    return (bpp >= 32'sd1) && (bpp <= 32'sd8);
  endfunction

  function automatic int drop_bits(input int bpp);
    return 32'sd8 - bpp;
  endfunction

  // Scale a matrix entry (0..3) so it spans the d dropped bits.
  function automatic logic [7:0] threshold(input logic [1:0] idx, input int d);
    logic [7:0] m_s;
    m_s = {6'd0, idx};
    if (d >= 32'sd2) begin
      threshold = m_s << (d - 32'sd2);
    end else if (d == 32'sd1) begin
      threshold = m_s >> 1;
    end else begin
      threshold = 8'd0;
    end
  endfunction

endpackage

// File: rtl/dither_channel.sv
// One colour channel: threshold add, saturate, truncate to the DAC depth and
// blank outside active video, across two ce_pix-qualified pipeline stages.
module dither_channel #(
  parameter int OUT_BPP = 6
) (
  input  logic               clk_vid,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [7:0]         pix_in,
  input  logic [7:0]         thr_in,
  input  logic               de_stage1,
  output logic [OUT_BPP-1:0] pix_out
);

  localparam int D = 8 - OUT_BPP;

  logic [8:0]         sum_s;
  logic [8:0]         sum_r;
  logic [OUT_BPP-1:0] sat_s;

  // Nine-bit sum keeps the carry so saturation never wraps to black.
  always_comb begin
    sum_s = {1'b0, pix_in} + {1'b0, thr_in};
    if (sum_r[8]) begin
      sat_s = {OUT_BPP{1'b1}};
    end else begin
      sat_s = sum_r[7:D];
    end
  end

  // Stage 1 holds the sum, stage 2 the blanked DAC code.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      sum_r   <= 9'd0;
      pix_out <= {OUT_BPP{1'b0}};
    end else if (ce_pix) begin
      sum_r   <= sum_s;
      pix_out <= de_stage1 ? sat_s : {OUT_BPP{1'b0}};
    end
  end

endmodule

// File: rtl/vga_dither_out.sv
// VGA DAC output stage: 2x2 ordered dither of 8-bit RGB down to OUT_BPP bits,
// with syncs and DE delay-matched through the same two-stage pipeline.
module vga_dither_out
  import video_dither_pkg::*;
#(
  parameter int OUT_BPP  = 6,
  parameter bit TEMPORAL = 1'b1
) (
  input  logic               clk_vid,
  input  logic               reset_n,
  input  logic               ce_pix,
  input  logic [7:0]         vid_r,
  input  logic [7:0]         vid_g,
  input  logic [7:0]         vid_b,
  input  logic               vid_hs,
  input  logic               vid_vs,
  input  logic               vid_de,
  input  logic               dither_en,
  output logic [OUT_BPP-1:0] vga_r,
  output logic [OUT_BPP-1:0] vga_g,
  output logic [OUT_BPP-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_de
);

  localparam int D = drop_bits(OUT_BPP);

  if (!bpp_legal(OUT_BPP)) begin : g_bpp_check
    $error("vga_dither_out: OUT_BPP must lie in 1..8");
  end

  logic       x_ph_r, y_ph_r, f_ph_r;
  logic       de_prev_r, vs_prev_r;
  logic       de_s1_r, hs_s1_r, vs_s1_r;
  logic       vs_rise_s, de_fall_s, xi_s, yi_s;
  logic [7:0] thr_s;

  // Matrix lookup uses the phases as they stand before this pixel's update.
  always_comb begin
    vs_rise_s = vid_vs & ~vs_prev_r;
    de_fall_s = ~vid_de & de_prev_r;
    xi_s      = x_ph_r ^ f_ph_r;
    yi_s      = y_ph_r ^ f_ph_r;
    if (dither_en) begin
      thr_s = threshold(BAYER2[yi_s][xi_s], D);
    end else begin
      thr_s = 8'd0;
    end
  end

  // Phase tracking; a vsync rise clears y_ph even when DE falls alongside it.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      x_ph_r    <= 1'b0;
      y_ph_r    <= 1'b0;
      f_ph_r    <= 1'b0;
      de_prev_r <= 1'b0;
      vs_prev_r <= 1'b0;
    end else if (ce_pix) begin
      de_prev_r <= vid_de;
      vs_prev_r <= vid_vs;
      x_ph_r    <= vid_de ? ~x_ph_r : 1'b0;
      if (vs_rise_s) begin
        y_ph_r <= 1'b0;
      end else if (de_fall_s) begin
        y_ph_r <= ~y_ph_r;
      end
      if (TEMPORAL && vs_rise_s) begin
        f_ph_r <= ~f_ph_r;
      end
    end
  end

  // Sync and DE delay line matching the colour pipeline.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      de_s1_r <= 1'b0;
      hs_s1_r <= 1'b0;
      vs_s1_r <= 1'b0;
      vga_de  <= 1'b0;
      vga_hs  <= 1'b0;
      vga_vs  <= 1'b0;
    end else if (ce_pix) begin
      de_s1_r <= vid_de;
      hs_s1_r <= vid_hs;
      vs_s1_r <= vid_vs;
      vga_de  <= de_s1_r;
      vga_hs  <= hs_s1_r;
      vga_vs  <= vs_s1_r;
    end
  end

  dither_channel #(.OUT_BPP(OUT_BPP)) u_ch_r (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .pix_in(vid_r), .thr_in(thr_s), .de_stage1(de_s1_r), .pix_out(vga_r)
  );

  dither_channel #(.OUT_BPP(OUT_BPP)) u_ch_g (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .pix_in(vid_g), .thr_in(thr_s), .de_stage1(de_s1_r), .pix_out(vga_g)
  );

  dither_channel #(.OUT_BPP(OUT_BPP)) u_ch_b (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .pix_in(vid_b), .thr_in(thr_s), .de_stage1(de_s1_r), .pix_out(vga_b)
  );

endmodule

// File: tb/tb_vga_dither_out.sv
// Scoreboard bench for vga_dither_out (OUT_BPP=6, TEMPORAL=1): the driver
// queues hand-computed results, a monitor pops them on every enabled edge.
module tb_vga_dither_out;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } out_t;

  logic       clk_vid = 1'b0;
  logic       reset_n;
  logic       ce_pix;
  logic [7:0] vid_r, vid_g, vid_b;
  logic       vid_hs, vid_vs, vid_de, dither_en;
  logic [5:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_de;

  out_t exp_q[$];
  out_t last_s;
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;

  always #5 clk_vid = ~clk_vid;

  vga_dither_out #(.OUT_BPP(6), .TEMPORAL(1'b1)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
    .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .dither_en(dither_en),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
  );

  function automatic out_t cur_out();
    return {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got r=%h g=%h b=%h hs=%b vs=%b de=%b, want r=%h g=%h b=%h hs=%b vs=%b de=%b",
               name, $time, act.r, act.g, act.b, act.hs, act.vs, act.de,
               exp.r, exp.g, exp.b, exp.hs, exp.vs, exp.de);
    end
  endtask

  // Drive one enabled pixel slot and queue what should emerge two enabled edges later.
  task automatic slot(input logic de, input logic hs, input logic vs, input logic den,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [5:0] er, input logic [5:0] eg, input logic [5:0] eb);
    vid_de = de; vid_hs = hs; vid_vs = vs; dither_en = den;
    vid_r = r; vid_g = g; vid_b = b;
    ce_pix = 1'b1;
    exp_q.push_back({er, eg, eb, hs, vs, de});
    @(negedge clk_vid);
  endtask

  task automatic px(input logic den, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [5:0] er, input logic [5:0] eg, input logic [5:0] eb);
    slot(1'b1, 1'b0, 1'b0, den, r, g, b, er, eg, eb);
  endtask

  task automatic blank(input logic hs, input logic vs, input logic [7:0] v);
    slot(1'b0, hs, vs, 1'b1, v, v, v, 6'h00, 6'h00, 6'h00);
  endtask

  // Disabled cycles with hostile inputs: nothing may move.
  task automatic skip3();
    ce_pix = 1'b0;
    vid_de = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1;
    vid_r = 8'hFF; vid_g = 8'h00; vid_b = 8'h55;
    repeat (3) @(negedge clk_vid);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk_vid);
      if (!reset_n) begin
        edges  = 0;
        last_s = '0;
      end else if (ce_pix) begin
        #1;
        edges++;
        if (edges >= 2) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow @%0t: output with no expected entry", $time);
          end else begin
            e = exp_q.pop_front();
            check("pixel", cur_out(), e);
          end
        end
        last_s = cur_out();
      end else begin
        #1;
        check("hold", cur_out(), last_s);
      end
    end
  end

  initial begin : driver
    reset_n = 1'b1; ce_pix = 1'b0; dither_en = 1'b1;
    vid_r = 8'h00; vid_g = 8'h00; vid_b = 8'h00;
    vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0;
    #1 reset_n = 1'b0;
    #2 check("reset", cur_out(), '0);
    repeat (2) @(negedge clk_vid);
    reset_n = 1'b1;

    // Frame 0 static 0x81 pattern
    blank(1'b0, 1'b0, 8'h00);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    blank(1'b1, 1'b0, 8'h00);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    blank(1'b1, 1'b0, 8'h00);
    // Saturation on row 0, then distinct per-channel values
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    px(1'b1, 8'h81, 8'hFE, 8'h02, 6'h20, 6'h3F, 6'h00);
    px(1'b1, 8'hFD, 8'hFE, 8'h02, 6'h3F, 6'h3F, 6'h01);
    blank(1'b1, 1'b0, 8'h00);
    // Saturation on row 1 (thresholds 3 and 1)
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    blank(1'b1, 1'b0, 8'h00);
    // Truncation, then dither back on mid-line
    px(1'b0, 8'h83, 8'h83, 8'h83, 6'h20, 6'h20, 6'h20);
    px(1'b0, 8'h83, 8'h83, 8'h83, 6'h20, 6'h20, 6'h20);
    px(1'b1, 8'h83, 8'h83, 8'h83, 6'h20, 6'h20, 6'h20);
    px(1'b1, 8'h83, 8'h83, 8'h83, 6'h21, 6'h21, 6'h21);
    // Blanking with bright input, then vsync into frame 1
    blank(1'b1, 1'b0, 8'hFF);
    blank(1'b0, 1'b1, 8'hFF);
    blank(1'b0, 1'b1, 8'hFF);
    blank(1'b0, 1'b0, 8'h00);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21);
    // DE fall and vsync rise together: row phase must clear, frame 2 = frame 0
    blank(1'b0, 1'b1, 8'h00);
    blank(1'b0, 1'b0, 8'h00);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    blank(1'b1, 1'b0, 8'h00);
    // 1-in-4 pixel enable on row 1
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21);
    skip3();
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    skip3();
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21);
    skip3();
    blank(1'b0, 1'b0, 8'h00);
    // Mid-line asynchronous reset with bright outputs
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    px(1'b1, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 6'h3F, 6'h3F);
    #2 reset_n = 1'b0;
    #1 check("async_reset", cur_out(), '0);
    exp_q.delete();
    repeat (2) @(negedge clk_vid);
    reset_n = 1'b1;
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h20, 6'h20, 6'h20);
    blank(1'b1, 1'b0, 8'h00);
    px(1'b1, 8'h81, 8'h81, 8'h81, 6'h21, 6'h21, 6'h21);
    blank(1'b0, 1'b0, 8'h00);
    blank(1'b0, 1'b0, 8'h00);
    blank(1'b0, 1'b0, 8'h00);
    ce_pix = 1'b0;
    repeat (3) @(negedge clk_vid);

    total++;
    if (exp_q.size() != 1) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 1", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
